dram_result_reader: RTL and testbench
=====================================

# dram_result_reader

Drains the product matrix from DRAM once the matrix-multiplier core finishes. It sits downstream of the core on the DRAM read port; the top level muxes DRAM address and read enable to it whenever the core is idle. It reads the result dimensions from a fixed header, then streams `rows*cols` result bytes in address order over a valid/ready byte interface toward the host link. It runs on the same divided core clock as the core and DRAM.

## Interface
- `ADDR_W`, 16: DRAM address width.
- `DATA_W`, 8: DRAM data width.
- `ROWS_ADDR`, 16'd0: DRAM address of the result row count.
- `COLS_ADDR`, 16'd1: DRAM address of the result column count.
- `RES_BASE`, 16'd2: DRAM address of result element (0,0), row-major.
- `RD_LAT`, 2: cycles from `o_dram_read` high to valid `i_dram_in`.
- `FIFO_DEPTH`, 4: output buffer depth; also the limit on outstanding reads.

Ports:
- `i_clk` in 1: core clock. All logic is on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_core_busy` in 1: core `o_busy`.
- `o_dram_addr` out ADDR_W: DRAM read address.
- `o_dram_read` out 1: DRAM read enable, one read per high cycle.
- `i_dram_in` in DATA_W: DRAM read data.
- `o_data` out DATA_W: result byte.
- `o_valid` out 1: `o_data` is valid.
- `i_ready` in 1: the sink accepts a byte when `o_valid && i_ready`.
- `o_active` out 1: the block owns the DRAM port. The top level gives DRAM to the block only while this is high.
- `o_done` out 1: one-cycle pulse after the last byte is accepted.
- `o_error` out 1: sticky abort flag.

## Operation
- States are IDLE, RD_HDR, WAIT_HDR, STREAM, DRAIN and DONE.
- **IDLE:** a registered falling edge of `i_core_busy` (1 then 0) moves the block to RD_HDR and clears `o_error`.
- **RD_HDR:**
  - Issue a read at ROWS_ADDR, then a read at COLS_ADDR on the next cycle.
  - Go to WAIT_HDR.
- **WAIT_HDR:**
  - Capture `rows` and `cols` as they return.
  - Compute `total = rows*cols` as an unsigned 2*DATA_W-bit product.
  - If `total == 0`, go to DONE without any result reads. Otherwise go to STREAM.
- **STREAM:**
  - Issue a read at `RES_BASE + idx` in any cycle where `fifo_count + outstanding < FIFO_DEPTH` and `idx < total`. After each read, `idx` increments.
  - Returned data is pushed into the FIFO. Overflow is impossible by construction.
  - When `idx == total`, go to DRAIN.
- **DRAIN:** wait until no reads are outstanding and the FIFO is empty, then go to DONE.
- **DONE:** pulse `o_done` for one cycle, then return to IDLE.
- **Abort:** if `i_core_busy` goes high in any state other than IDLE or DONE:
  - Set `o_error`.
  - Stop issuing reads, flush the FIFO and discard in-flight returns.
  - Drop `o_valid` and return to IDLE with no `o_done`.
- `o_active` is high in every state except IDLE.
- `o_dram_addr` holds its last value when `o_dram_read` is low.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. No saturation.

## Timing
- **Reset values:**
  - All outputs are 0, including `o_dram_addr`.
  - The state is IDLE, the FIFO is empty and the return pipeline is cleared.
  - A reset in the middle of a transfer discards everything immediately. No DRAM reads are issued until the next trigger.
- **Trigger to DRAM:** `o_dram_read` first goes high 2 cycles after the cycle in which `i_core_busy` is sampled low (1 cycle for edge detect, 1 cycle for the IDLE→RD_HDR transition).
- **Read return:** returns are tracked by an RD_LAT-deep shift register of valid bits. Data is pushed into the FIFO in the cycle it is valid.
- **Output path:** the FIFO is first-word-fall-through. `o_valid` rises in the cycle after the push.
  - `o_data` and `o_valid` stay stable while `o_valid && !i_ready`.
  - With `i_ready` held high and RD_LAT=2, throughput is 1 byte per cycle after the first byte.
- **Push and pop together:** `fifo_count` is unchanged.
- **End of transfer:** `o_done` occurs in the cycle after the final handshake.

## Structure
- The shared package `mm_pkg` holds:
  - ADDR_W and DATA_W defaults.
  - The header address constants, which the core and loader also use.
  - The state enum.
- There is one sub-module, `sync_fifo` (parameters DEPTH and WIDTH, FWFT, with count output), for reuse by the upstream loader.
- The return valid shift register and read credit counter live in the top block.

## Test plan
- **2x3 result:** DRAM[0]=2, DRAM[1]=3, DRAM[2..7]=0x10..0x15, busy 1→0, `i_ready`=1. Required response:
  - Exactly 8 reads, to addresses 0, 1, then 2..7.
  - Output bytes 0x10..0x15 in order.
  - One `o_done` pulse, with `o_active` low afterward.
- **Backpressure:** 4x4 result with `i_ready` toggling 1/0 every cycle. Required response:
  - All 16 bytes arrive in order with no duplicates.
  - Outstanding reads plus FIFO count never exceed 4.
  - `o_data` is stable while stalled.
- **Zero dimension:** rows=0, cols=5. Required response: only 2 header reads, `o_valid` never high, `o_done` pulses.
- **Abort:** 8x8 result, raise `i_core_busy` after 10 bytes are accepted. Required response:
  - `o_error`=1 and `o_valid` drops.
  - No further reads and no `o_done`.
  - A later busy falling edge restarts cleanly from address 0 and clears `o_error`.
- **Reset mid-stream:** `i_rst_n` low asynchronously during STREAM. Required response: all outputs 0 immediately and no stale byte after reset is released.
- **Sink stalled:** 1x255 result with `i_ready`=0 for 50 cycles, then 1. Required response: the read count stalls at 2+4, then all 255 bytes are delivered.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg: shared constants and state encoding for the matrix-multiplier datapath
//   MM_ADDR_W / MM_DATA_W : default DRAM address and data widths
//   MM_*_ADDR / MM_RES_BASE : fixed result header and element locations in DRAM
//   rd_state_t            : result reader state encoding
package mm_pkg;
    localparam int MM_ADDR_W = 16;
    localparam int MM_DATA_W = 8;
    localparam logic [15:0] MM_ROWS_ADDR = 16'd0;
    localparam logic [15:0] MM_COLS_ADDR = 16'd1;
    localparam logic [15:0] MM_RES_BASE = 16'd2;
    typedef enum logic [2:0] {IDLE, RD_HDR, WAIT_HDR, STREAM, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous clear of all contents (wins over push/pop)
//   push, wdata       : write port; the caller never pushes when full
//   pop               : consume the head word (ignored when empty)
//   rdata, valid      : head word (0 when empty) and non-empty flag
//   count             : current occupancy
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           valid,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid  = (count != '0);
    assign rdata  = valid ? mem[rd_ptr] : '0;
    assign do_pop = pop && valid;

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/dram_result_reader.sv
// dram_result_reader: drains the product matrix from DRAM after the core finishes
//   i_clk, i_rst_n      : core clock, asynchronous active-low reset
//   i_core_busy         : core busy; a falling edge starts a drain, a rise mid-drain aborts
//   o_dram_addr/o_dram_read/i_dram_in : DRAM read port (data RD_LAT cycles after read)
//   o_data/o_valid/i_ready : result byte stream toward the host link
//   o_active            : block owns the DRAM port
//   o_done              : one-cycle pulse after the last byte is accepted
//   o_error             : sticky abort flag, cleared on the next start
module dram_result_reader
    import mm_pkg::*;
#(
    parameter int                ADDR_W     = MM_ADDR_W,
    parameter int                DATA_W     = MM_DATA_W,
    parameter logic [ADDR_W-1:0] ROWS_ADDR  = ADDR_W'(MM_ROWS_ADDR),
    parameter logic [ADDR_W-1:0] COLS_ADDR  = ADDR_W'(MM_COLS_ADDR),
    parameter logic [ADDR_W-1:0] RES_BASE   = ADDR_W'(MM_RES_BASE),
    parameter int                RD_LAT     = 2,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_core_busy,
    output logic [ADDR_W-1:0] o_dram_addr,
    output logic              o_dram_read,
    input  logic [DATA_W-1:0] i_dram_in,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_active,
    output logic              o_done,
    output logic              o_error
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = 2 * DATA_W;
    localparam logic [CW:0] LIMIT = (CW + 1)'(FIFO_DEPTH);

    rd_state_t state, state_n;
    logic busy_q, fall_q, hdr_phase, got_rows;
    logic [RD_LAT-1:0] ret_sr;
    logic [DATA_W-1:0] rows;
    logic [TW-1:0] total, idx, prod;
    logic [CW-1:0] outstanding, fifo_count;
    logic [CW:0] occ;
    logic [ADDR_W-1:0] addr_q;
    logic abort, ret, push, pop, rd_data, hdr_rd, fifo_valid;

    // A rise of busy while we own DRAM means the core restarted under us.
    assign abort   = i_core_busy && state != IDLE && state != DONE;
    assign ret     = ret_sr[RD_LAT-1];
    assign prod    = TW'(rows) * TW'(i_dram_in);
    assign push    = ret && (state == STREAM || state == DRAIN) && !abort;
    assign occ     = {1'b0, fifo_count} + {1'b0, outstanding};
    // Credits cover both buffered bytes and reads still in flight, so the FIFO can never overflow.
    assign rd_data = state == STREAM && !abort && idx < total && occ < LIMIT;
    assign hdr_rd  = state == RD_HDR && !abort;
    assign o_dram_read = hdr_rd || rd_data;
    assign o_dram_addr = !o_dram_read ? addr_q :
                         hdr_rd ? (hdr_phase ? COLS_ADDR : ROWS_ADDR) :
                         RES_BASE + ADDR_W'(idx);
    assign o_valid  = fifo_valid && !abort;
    assign pop      = o_valid && i_ready;
    assign o_active = state != IDLE;
    assign o_done   = state == DONE;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .flush (abort),
        .push  (push),
        .wdata (i_dram_in),
        .pop   (pop),
        .rdata (o_data),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (fall_q) state_n = RD_HDR;
            RD_HDR:   if (hdr_phase) state_n = WAIT_HDR;
            WAIT_HDR: if (ret && got_rows) state_n = (prod == '0) ? DONE : STREAM;
            STREAM:   if (idx == total) state_n = DRAIN;
            // Leave in the cycle of the final handshake so o_done follows it directly.
            DRAIN:    if (outstanding == '0 && (fifo_count == '0 || (fifo_count == CW'(1) && pop)))
                          state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            fall_q      <= 1'b0;
            hdr_phase   <= 1'b0;
            got_rows    <= 1'b0;
            ret_sr      <= '0;
            rows        <= '0;
            total       <= '0;
            idx         <= '0;
            outstanding <= '0;
            addr_q      <= '0;
            o_error     <= 1'b0;
        end else begin
            state       <= state_n;
            busy_q      <= i_core_busy;
            fall_q      <= busy_q && !i_core_busy;
            hdr_phase   <= hdr_rd && !hdr_phase;
            ret_sr      <= abort ? '0 : RD_LAT'({ret_sr, o_dram_read});
            addr_q      <= o_dram_addr;
            outstanding <= abort ? '0 : outstanding + CW'(rd_data) - CW'(push);
            if (rd_data) idx <= idx + 1'b1;
            if (state == IDLE) begin
                idx      <= '0;
                got_rows <= 1'b0;
            end
            // Header returns arrive in issue order: rows first, then cols.
            if (state == WAIT_HDR && ret && !abort) begin
                if (!got_rows) begin
                    rows     <= i_dram_in;
                    got_rows <= 1'b1;
                end else begin
                    total <= prod;
                end
            end
            if (state == IDLE && fall_q) o_error <= 1'b0;
            if (abort) o_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dram_result_reader.sv
// tb_dram_result_reader: randomized scenario bench for dram_result_reader with a DRAM model
module tb_dram_result_reader;
    import mm_pkg::*;
    localparam int MEM = 512;

    logic clk = 1'b0, rst_n = 1'b1, busy = 1'b0, ready = 1'b0;
    logic [15:0] dram_addr;
    logic dram_read, valid, active, done, error;
    logic [7:0] dram_in, data;
    logic [7:0] mem [MEM];
    logic [7:0] pipe [2] = '{8'hA5, 8'hA5};
    int checks = 0, errors = 0, cyc = 0, trig_cyc = 0, ready_mode = 0;
    logic [15:0] rd_log[$], exp_a[$];
    logic [7:0] out_log[$], exp_b[$];
    int done_cnt, valid_seen, first_rd_cyc, last_hs_cyc, done_cyc, max_occ, stall_err;
    logic prev_stall;
    logic [7:0] prev_data;

    dram_result_reader dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_core_busy(busy),
        .o_dram_addr(dram_addr), .o_dram_read(dram_read), .i_dram_in(dram_in),
        .o_data(data), .o_valid(valid), .i_ready(ready),
        .o_active(active), .o_done(done), .o_error(error)
    );

    always #5 clk = ~clk;

    // DRAM: data for a read sampled at an edge appears two edges later.
    always @(posedge clk) begin
        pipe[1] <= pipe[0];
        pipe[0] <= dram_read ? mem[dram_addr[8:0]] : 8'hA5;
    end
    assign dram_in = pipe[1];

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: ready = 1'b1;
            1: ready = ~ready;
            2: ready = 1'b0;
            default: ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Observe mid-cycle: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        int occ;
        cyc++;
        if (rst_n) begin
            if (dram_read) begin
                if (rd_log.size() == 0) first_rd_cyc = cyc;
                rd_log.push_back(dram_addr);
            end
            if (rd_log.size() > 2) begin
                occ = int'(rd_log.size()) - 2 - int'(out_log.size());
                if (occ > max_occ) max_occ = occ;
            end
            if (prev_stall && (!valid || data !== prev_data)) stall_err++;
            prev_stall = valid && !ready;
            prev_data = data;
            if (valid) valid_seen++;
            if (valid && ready) begin
                out_log.push_back(data);
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_logs();
        rd_log.delete();
        out_log.delete();
        done_cnt = 0; valid_seen = 0; first_rd_cyc = -1; last_hs_cyc = -1;
        done_cyc = -1; max_occ = 0; stall_err = 0; prev_stall = 1'b0;
    endtask

    // Reference: header reads at 0,1 then one read per element in address order,
    // and the element bytes delivered unchanged in that same order.
    task automatic load(input int r, input int c, input bit seq);
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < MEM; i++) mem[i] = 8'($urandom);
        mem[0] = 8'(r);
        mem[1] = 8'(c);
        exp_a.push_back(16'd0);
        exp_a.push_back(16'd1);
        for (int k = 0; k < r * c; k++) begin
            if (seq) mem[2 + k] = 8'(16 + k);
            exp_a.push_back(16'(2 + k));
            exp_b.push_back(mem[2 + k]);
        end
    endtask

    task automatic trigger();
        @(posedge clk); #1 busy = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear_logs();
        busy = 1'b0;
        trig_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            ok = done_cnt > 0;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({dram_addr, dram_read, data, valid, active, done, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {dram_addr, dram_read, data, valid, active, done, error});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (active !== 1'b0 || dram_read !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: active %b read %b required 0 0", active, dram_read);
        end
    endtask

    task automatic test_2x3();
        bit ok;
        int bad = -1;
        ready_mode = 0;
        load(2, 3, 1'b1);
        trigger();
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL 2x3_timeout: done %0d required 1", done_cnt); end
        checks++;
        if (first_rd_cyc - trig_cyc != 3) begin
            errors++; $display("FAIL 2x3_trigger_latency: got %0d required 3", first_rd_cyc - trig_cyc);
        end
        foreach (exp_a[i]) if (bad < 0 && (i >= rd_log.size() || rd_log[i] !== exp_a[i])) bad = i;
        checks++;
        if (bad >= 0 || rd_log.size() != exp_a.size()) begin
            errors++; $display("FAIL 2x3_reads: got %0d reads diff at %0d required %0d", rd_log.size(), bad, exp_a.size());
        end
        bad = -1;
        foreach (exp_b[i]) if (bad < 0 && (i >= out_log.size() || out_log[i] !== exp_b[i])) bad = i;
        checks++;
        if (bad >= 0 || out_log.size() != exp_b.size()) begin
            errors++; $display("FAIL 2x3_bytes: got %0d bytes diff at %0d required %0d", out_log.size(), bad, exp_b.size());
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            errors++; $display("FAIL 2x3_done: got %0d pulses at +%0d required 1 at +1", done_cnt, done_cyc - last_hs_cyc);
        end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL 2x3_active: got %b required 0", active); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad = -1;
        ready_mode = 1;
        load(4, 4, 1'b0);
        trigger();
        wait_done(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout: done %0d required 1", done_cnt); end
        foreach (exp_b[i]) if (bad < 0 && (i >= out_log.size() || out_log[i] !== exp_b[i])) bad = i;
        checks++;
        if (bad >= 0 || out_log.size() != exp_b.size()) begin
            errors++; $display("FAIL bp_bytes: got %0d bytes diff at %0d required %0d", out_log.size(), bad, exp_b.size());
        end
        checks++;
        if (max_occ > 4) begin errors++; $display("FAIL bp_occupancy: got %0d required <= 4", max_occ); end
        checks++;
        if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes required 0", stall_err); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL bp_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_zero();
        bit ok;
        ready_mode = 0;
        load(0, 5, 1'b0);
        trigger();
        wait_done(100, ok);
        checks++;
        if (!ok || done_cnt != 1) begin errors++; $display("FAIL zero_done: got %0d required 1", done_cnt); end
        checks++;
        if (rd_log.size() != 2 || rd_log[0] !== 16'd0 || rd_log[1] !== 16'd1) begin
            errors++; $display("FAIL zero_reads: got %0d reads required 2 at 0,1", rd_log.size());
        end
        checks++;
        if (valid_seen != 0) begin errors++; $display("FAIL zero_valid: got %0d cycles required 0", valid_seen); end
    endtask

    task automatic test_abort();
        bit ok;
        int bad = -1, snap;
        ready_mode = 0;
        load(8, 8, 1'b0);
        trigger();
        for (int i = 0; i < 300 && out_log.size() < 10; i++) begin @(negedge clk); #1; end
        checks++;
        if (out_log.size() != 10) begin errors++; $display("FAIL abort_reach10: got %0d required 10", out_log.size()); end
        @(posedge clk); #1 busy = 1'b1;
        snap = rd_log.size();
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (error !== 1'b1 || valid !== 1'b0 || active !== 1'b0) begin
            errors++; $display("FAIL abort_flags: error %b valid %b active %b required 1 0 0", error, valid, active);
        end
        checks++;
        if (rd_log.size() != snap || done_cnt != 0 || out_log.size() != 10) begin
            errors++;
            $display("FAIL abort_quiet: reads +%0d done %0d bytes %0d required +0 0 10", rd_log.size() - snap, done_cnt, out_log.size());
        end
        for (int i = 0; i < 10 && i < out_log.size(); i++) if (bad < 0 && out_log[i] !== exp_b[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL abort_prefix: got %h required %h", out_log[bad], exp_b[bad]); end
        load(3, 2, 1'b0);
        trigger();
        wait_done(200, ok);
        bad = -1;
        foreach (exp_a[i]) if (bad < 0 && (i >= rd_log.size() || rd_log[i] !== exp_a[i])) bad = i;
        checks++;
        if (!ok || bad >= 0 || rd_log.size() != exp_a.size()) begin
            errors++; $display("FAIL restart_reads: got %0d reads diff at %0d required %0d", rd_log.size(), bad, exp_a.size());
        end
        bad = -1;
        foreach (exp_b[i]) if (bad < 0 && (i >= out_log.size() || out_log[i] !== exp_b[i])) bad = i;
        checks++;
        if (bad >= 0 || out_log.size() != exp_b.size() || error !== 1'b0) begin
            errors++; $display("FAIL restart_bytes: got %0d bytes error %b required %0d bytes error 0", out_log.size(), error, exp_b.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad = -1;
        ready_mode = 0;
        load(6, 6, 1'b0);
        trigger();
        for (int i = 0; i < 300 && out_log.size() < 5; i++) begin @(negedge clk); #1; end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dram_addr, dram_read, data, valid, active, done, error} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h required 0", {dram_addr, dram_read, data, valid, active, done, error});
        end
        repeat (3) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        checks++;
        if (rd_log.size() != 0 || valid_seen != 0) begin
            errors++; $display("FAIL midreset_stale: got %0d reads %0d valid required 0 0", rd_log.size(), valid_seen);
        end
        load(2, 2, 1'b0);
        trigger();
        wait_done(200, ok);
        foreach (exp_b[i]) if (bad < 0 && (i >= out_log.size() || out_log[i] !== exp_b[i])) bad = i;
        checks++;
        if (!ok || bad >= 0 || out_log.size() != exp_b.size()) begin
            errors++; $display("FAIL midreset_rerun: got %0d bytes diff at %0d required %0d", out_log.size(), bad, exp_b.size());
        end
    endtask

    task automatic test_sink_stall();
        bit ok;
        int bad = -1;
        ready_mode = 2;
        load(1, 255, 1'b0);
        trigger();
        repeat (50) @(negedge clk);
        #1;
        checks++;
        if (rd_log.size() != 6 || max_occ != 4) begin
            errors++; $display("FAIL stall_reads: got %0d reads occ %0d required 6 reads occ 4", rd_log.size(), max_occ);
        end
        checks++;
        if (valid !== 1'b1 || data !== exp_b[0]) begin
            errors++; $display("FAIL stall_head: got valid %b data %h required 1 %h", valid, data, exp_b[0]);
        end
        ready_mode = 0;
        wait_done(1000, ok);
        foreach (exp_b[i]) if (bad < 0 && (i >= out_log.size() || out_log[i] !== exp_b[i])) bad = i;
        checks++;
        if (!ok || bad >= 0 || out_log.size() != 255) begin
            errors++; $display("FAIL stall_bytes: got %0d bytes diff at %0d required 255", out_log.size(), bad);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            bit ok;
            int bad = -1, r = $urandom_range(0, 5), c = $urandom_range(1, 7);
            ready_mode = 3;
            load(r, c, 1'b0);
            trigger();
            wait_done(600, ok);
            foreach (exp_a[i]) if (bad < 0 && (i >= rd_log.size() || rd_log[i] !== exp_a[i])) bad = i;
            checks++;
            if (!ok || bad >= 0 || rd_log.size() != exp_a.size()) begin
                errors++; $display("FAIL rand%0d_reads: got %0d reads diff at %0d required %0d", n, rd_log.size(), bad, exp_a.size());
            end
            bad = -1;
            foreach (exp_b[i]) if (bad < 0 && (i >= out_log.size() || out_log[i] !== exp_b[i])) bad = i;
            checks++;
            if (bad >= 0 || out_log.size() != exp_b.size() || max_occ > 4) begin
                errors++;
                $display("FAIL rand%0d_bytes: got %0d bytes diff at %0d occ %0d required %0d occ <= 4", n, out_log.size(), bad, max_occ, exp_b.size());
            end
            checks++;
            if (done_cnt != 1 || (r * c > 0 && done_cyc != last_hs_cyc + 1)) begin
                errors++; $display("FAIL rand%0d_done: got %0d pulses at +%0d required 1 at +1", n, done_cnt, done_cyc - last_hs_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_2x3();
        test_backpressure();
        test_zero();
        test_abort();
        test_reset_mid();
        test_sink_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
